spdif_rx_dma_buffer: RTL and testbench
======================================

Name: spdif_rx_dma_buffer

Overview:
- Capture buffer between the SPDIF receiver and the DMA controller; it is DMA device 0.
- Packs 32-bit received subframes four at a time into 128-bit lines in a 128-line ping-pong RAM of two 64-line halves.
- Flags each completed half to software.
- The DMA controller reads the lines out and can write them over the same device port.

Parameters:
- LINES, 128, total lines; must be even; address width is clog2(LINES)=7.
- LINE_W, 128, line width in bits.
- SUB_W, 32, subframe width; LINE_W/SUB_W = 4 slots per line.

Ports:
- clk_i  in  1  sole clock.
- rst_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  capture enable; low holds the packer idle at line 0, slot 0.
- sub_dat_i  in  32  received subframe.
- sub_valid_i  in  1  one-cycle strobe; sub_dat_i is valid; no backpressure.
- sub_first_i  in  1  qualifies sub_valid_i; subframe is first of a frame (preamble B/M).
- dma_en_i  in  1  DMA read enable.
- dma_we_i  in  1  DMA write enable.
- dma_adr_i  in  7  DMA line address.
- dma_dat_i  in  128  DMA write data.
- dma_dat_o  out  128  DMA read data.
- half_ack_i  in  2  per-half acknowledge pulses from the register block.
- clr_i  in  1  clears the sticky flags.
- half_full_o  out  2  half h completed and not yet acknowledged.
- overrun_o  out  1  sticky: a half was re-entered while still full.
- misalign_o  out  1  sticky: a frame start arrived mid-line.
- collide_o  out  1  sticky: a DMA write was dropped.
- irq_o  out  1  registered OR of half_full_o.

Behaviour:
- Reset: all outputs 0, line pointer 0, slot 0, holding register 0. RAM contents are not reset and are undefined. An asserted reset mid-transfer aborts immediately; the partial line is lost.
- Packer, per accepted subframe (sub_valid_i & enable_i):
  - Slot s receives bits [32s+31:32s] of the holding register.
  - On slot 3, at the same posedge, the full line (holding bits [95:0] plus the current subframe) is written to RAM[line]. Line increments and slot returns to 0.
  - Write latency is one clock from the 4th strobe.
- Alignment: sub_valid_i & sub_first_i with slot!=0 discards the partial line. The current subframe goes into slot 0 of the same line, and misalign_o is set.
- Line wrap: after the write to line 63, half_full_o[0] is set; after line 127, half_full_o[1] is set and line wraps to 0.
- Overrun:
  - The first write into half h while half_full_o[h]=1 sets overrun_o.
  - The write still proceeds, overwriting that line.
  - half_full_o[h] stays set.
- enable_i low: slot and line return to 0 on the next clock and strobes are ignored. Flags are retained.
- half_ack_i[h] clears half_full_o[h]. If a set for h occurs in the same cycle, the set wins.
- clr_i clears overrun_o, misalign_o and collide_o. A same-cycle set wins.
- DMA read: dma_dat_o = RAM[dma_adr_i] combinationally (asynchronous read); it is valid whenever dma_en_i is high. When dma_en_i is low, dma_dat_o is don't-care.
- DMA write:
  - RAM[dma_adr_i] <= dma_dat_i at posedge when dma_we_i is high, independent of dma_en_i.
  - If the packer writes in the same cycle, the packer wins, the DMA write is dropped, and collide_o is set (even for different addresses; single write port).
- Read-during-write to the same address returns the old data until the posedge.
- irq_o follows half_full_o with one clock delay.

Decomposition:
- Shared package spdif_dma_pkg holds:
  - DMA_ADR_W=7, DMA_DAT_W=128, SUB_W=32.
  - Device index constants DEV_SPDIF_RX=0, DEV_SPDIF_TX=1, DEV_I2S_TX=2, DEV_MEM=3.
- One sub-module: spdif_line_ram, LINES x LINE_W, one write port, one asynchronous read port. The packer, flags and arbitration stay in the top module.

Test Plan:
- Reset, then enable_i=1 and 4 strobes with data 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> RAM[0]=0x44444444_33333333_22222222_11111111 one clock after the 4th strobe; dma_adr_i=0, dma_en_i=1 reads that value; pointer is at line 1, slot 0.
- 256 strobes (64 lines) -> half_full_o=2'b01 on the clock after the line-63 write and irq_o one clock later. half_ack_i=2'b01 -> half_full_o=0 and irq_o low the clock after.
- 512 strobes with no ack, then 4 more -> half_full_o=2'b11, overrun_o=1, RAM[0] overwritten with the new data; clr_i=1 -> overrun_o=0.
- Strobes 0xA, 0xB, then a strobe with sub_first_i=1 and data 0xC -> misalign_o=1; after 3 more strobes RAM[0] slot 0 holds 0xC; 0xA and 0xB are never written.
- DMA write to address 5 with 0xDEAD.. in the same cycle as the packer's line-0 write -> RAM[5] unchanged, collide_o=1, RAM[0] correct. A DMA write to address 5 in an idle cycle -> RAM[5] updated.
- Assert rst_i asynchronously mid-line (slot 2, half_full_o=01, overrun_o=1) -> all flags and irq_o drop before the next clock edge; the next 4 strobes write line 0.

Source files
------------

// File: rtl/spdif_dma_pkg.sv
// spdif_dma_pkg: shared DMA bus widths, subframe width and DMA device indices.
package spdif_dma_pkg;
    localparam int DMA_ADR_W = 7;
    localparam int DMA_DAT_W = 128;
    localparam int SUB_W     = 32;

    localparam int DEV_SPDIF_RX = 0;
    localparam int DEV_SPDIF_TX = 1;
    localparam int DEV_I2S_TX   = 2;
    localparam int DEV_MEM      = 3;
endpackage

// File: rtl/spdif_rx_dma_buffer_if.sv
// spdif_rx_dma_buffer_if: DMA device port (en, we, adr, wdat from the controller; rdat back to it).
interface spdif_rx_dma_buffer_if;
    import spdif_dma_pkg::*;
    logic                 en;
    logic                 we;
    logic [DMA_ADR_W-1:0] adr;
    logic [DMA_DAT_W-1:0] wdat;
    logic [DMA_DAT_W-1:0] rdat;

    modport master (output en, we, adr, wdat, input rdat);
    modport slave  (input en, we, adr, wdat, output rdat);
endinterface

// File: rtl/spdif_line_ram.sv
// spdif_line_ram: LINES x LINE_W storage, one synchronous write port, one asynchronous read port.
// Ports: clk_i; we_i/wadr_i/wdat_i write at posedge; radr_i -> rdat_o combinationally.
module spdif_line_ram #(
    parameter int LINES  = 128,
    parameter int LINE_W = 128,
    parameter int ADR_W  = $clog2(LINES)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADR_W-1:0]  wadr_i,
    input  logic [LINE_W-1:0] wdat_i,
    input  logic [ADR_W-1:0]  radr_i,
    output logic [LINE_W-1:0] rdat_o
);
    logic [LINE_W-1:0] mem [LINES];

    always_ff @(posedge clk_i)
        if (we_i) mem[wadr_i] <= wdat_i;

    assign rdat_o = mem[radr_i];
endmodule

// File: rtl/spdif_rx_dma_buffer.sv
// spdif_rx_dma_buffer: packs SPDIF subframes into lines of a ping-pong RAM served as DMA device 0.
// Ports: clk_i/rst_i (async, active high); enable_i, sub_dat_i/sub_valid_i/sub_first_i subframe input;
// dma (slave) line read/write port; half_ack_i/clr_i flag clears; half_full_o, overrun_o,
// misalign_o, collide_o, irq_o status.
module spdif_rx_dma_buffer
    import spdif_dma_pkg::*;
#(
    parameter int LINES  = 128,
    parameter int LINE_W = spdif_dma_pkg::DMA_DAT_W,
    parameter int SUB_W  = spdif_dma_pkg::SUB_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [SUB_W-1:0]  sub_dat_i,
    input  logic              sub_valid_i,
    input  logic              sub_first_i,
    spdif_rx_dma_buffer_if.slave dma,
    input  logic [1:0]        half_ack_i,
    input  logic              clr_i,
    output logic [1:0]        half_full_o,
    output logic              overrun_o,
    output logic              misalign_o,
    output logic              collide_o,
    output logic              irq_o
);
    localparam int ADR_W  = $clog2(LINES);
    localparam int SLOTS  = LINE_W / SUB_W;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int HOLD_W = LINE_W - SUB_W;

    logic [SLOT_W-1:0] slot, eff_slot;
    logic [ADR_W-1:0]  line;
    logic [HOLD_W-1:0] hold;
    logic              acc, realign, last_slot, pk_we, half, half_end, dma_we;
    logic [1:0]        hf_set;
    logic [ADR_W-1:0]  ram_wadr;
    logic [LINE_W-1:0] ram_wdat, ram_rdat;

    assign acc       = sub_valid_i & enable_i;
    // a frame start in mid-line restarts the current line at slot 0
    assign realign   = acc & sub_first_i & (slot != '0);
    assign eff_slot  = realign ? '0 : slot;
    assign last_slot = eff_slot == SLOT_W'(SLOTS - 1);
    assign pk_we     = acc & last_slot;
    assign half      = line[ADR_W-1];
    assign half_end  = &line[ADR_W-2:0];
    assign hf_set    = (pk_we & half_end) ? (2'b01 << half) : 2'b00;
    assign dma_we    = dma.we;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot <= '0;
            line <= '0;
            hold <= '0;
        end else if (!enable_i) begin
            slot <= '0;
            line <= '0;
        end else if (acc) begin
            if (last_slot) begin
                slot <= '0;
                line <= line + 1'b1;
            end else begin
                hold[SUB_W*eff_slot +: SUB_W] <= sub_dat_i;
                slot <= eff_slot + 1'b1;
            end
        end
    end

    // sets take priority over same-cycle acknowledges and clears
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            half_full_o <= '0;
            overrun_o   <= 1'b0;
            misalign_o  <= 1'b0;
            collide_o   <= 1'b0;
            irq_o       <= 1'b0;
        end else begin
            half_full_o <= (half_full_o & ~half_ack_i) | hf_set;
            overrun_o   <= (overrun_o & ~clr_i) | (pk_we & half_full_o[half]);
            misalign_o  <= (misalign_o & ~clr_i) | realign;
            collide_o   <= (collide_o & ~clr_i) | (pk_we & dma_we);
            irq_o       <= |half_full_o;
        end
    end

    // single write port: a packer line write pre-empts any DMA write in the same cycle
    assign ram_wadr = pk_we ? line : dma.adr;
    assign ram_wdat = pk_we ? {sub_dat_i, hold} : dma.wdat;

    spdif_line_ram #(.LINES(LINES), .LINE_W(LINE_W), .ADR_W(ADR_W)) u_ram (
        .clk_i  (clk_i),
        .we_i   (pk_we | dma_we),
        .wadr_i (ram_wadr),
        .wdat_i (ram_wdat),
        .radr_i (dma.adr),
        .rdat_o (ram_rdat)
    );

    assign dma.rdat = dma.en ? ram_rdat : '0;
endmodule

// File: tb/tb_spdif_rx_dma_buffer.sv
// tb_spdif_rx_dma_buffer: directed self-checking bench for spdif_rx_dma_buffer.
module tb_spdif_rx_dma_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] sub_dat = '0;
    logic        sub_valid = 1'b0;
    logic        sub_first = 1'b0;
    logic [1:0]  half_ack = '0;
    logic        clr = 1'b0;
    logic [1:0]  half_full;
    logic        overrun, misalign, collide, irq;
    int          checks = 0;
    int          errors = 0;

    spdif_rx_dma_buffer_if dma_bus ();

    spdif_rx_dma_buffer dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .sub_dat_i   (sub_dat),
        .sub_valid_i (sub_valid),
        .sub_first_i (sub_first),
        .dma         (dma_bus),
        .half_ack_i  (half_ack),
        .clr_i       (clr),
        .half_full_o (half_full),
        .overrun_o   (overrun),
        .misalign_o  (misalign),
        .collide_o   (collide),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        enable = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
    endtask

    task automatic strobe(input logic [31:0] d, input logic f);
        sub_dat = d;
        sub_first = f;
        sub_valid = 1'b1;
        @(negedge clk);
        sub_valid = 1'b0;
        sub_first = 1'b0;
    endtask

    task automatic read_line(input logic [6:0] a, output logic [127:0] d);
        dma_bus.adr = a;
        dma_bus.en = 1'b1;
        #1;
        d = dma_bus.rdat;
    endtask

    task automatic test_reset();
        logic [6:0] flags;
        rst = 1'b1;
        @(negedge clk);
        flags = {half_full, overrun, misalign, collide, irq, 1'b0};
        checks++;
        if (flags !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b expected %b", flags, 7'b0);
        end
        do_reset();
    endtask

    task automatic test_pack();
        logic [127:0] d;
        do_reset();
        strobe(32'h11111111, 1'b0);
        strobe(32'h22222222, 1'b0);
        strobe(32'h33333333, 1'b0);
        strobe(32'h44444444, 1'b0);
        read_line(7'd0, d);
        checks++;
        if (d !== 128'h44444444_33333333_22222222_11111111) begin
            errors++;
            $display("FAIL pack_line0 got %h expected %h", d, 128'h44444444_33333333_22222222_11111111);
        end
        strobe(32'h55555555, 1'b0);
        strobe(32'h66666666, 1'b0);
        strobe(32'h77777777, 1'b0);
        strobe(32'h88888888, 1'b0);
        read_line(7'd1, d);
        checks++;
        if (d !== 128'h88888888_77777777_66666666_55555555) begin
            errors++;
            $display("FAIL pack_line1 got %h expected %h", d, 128'h88888888_77777777_66666666_55555555);
        end
    endtask

    task automatic test_half_full();
        logic [127:0] d;
        do_reset();
        for (int i = 0; i < 255; i++) strobe(i, 1'b0);
        checks++;
        if (half_full !== 2'b00) begin
            errors++;
            $display("FAIL half_early got %b expected 00", half_full);
        end
        strobe(32'd255, 1'b0);
        checks++;
        if (half_full !== 2'b01 || irq !== 1'b0) begin
            errors++;
            $display("FAIL half0_set got hf=%b irq=%b expected hf=01 irq=0", half_full, irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_rise got %b expected 1", irq);
        end
        read_line(7'd63, d);
        checks++;
        if (d !== {32'd255, 32'd254, 32'd253, 32'd252}) begin
            errors++;
            $display("FAIL line63 got %h expected %h", d, {32'd255, 32'd254, 32'd253, 32'd252});
        end
        half_ack = 2'b01;
        @(negedge clk);
        half_ack = 2'b00;
        checks++;
        if (half_full !== 2'b00 || irq !== 1'b1) begin
            errors++;
            $display("FAIL half_ack got hf=%b irq=%b expected hf=00 irq=1", half_full, irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_fall got %b expected 0", irq);
        end
    endtask

    task automatic test_overrun();
        logic [127:0] d;
        do_reset();
        for (int i = 0; i < 512; i++) strobe(i, 1'b0);
        checks++;
        if (half_full !== 2'b11 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL wrap_full got hf=%b ovr=%b expected hf=11 ovr=0", half_full, overrun);
        end
        read_line(7'd127, d);
        checks++;
        if (d !== {32'd511, 32'd510, 32'd509, 32'd508}) begin
            errors++;
            $display("FAIL line127 got %h expected %h", d, {32'd511, 32'd510, 32'd509, 32'd508});
        end
        for (int i = 0; i < 4; i++) strobe(32'hE0 + i, 1'b0);
        checks++;
        if (half_full !== 2'b11 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set got hf=%b ovr=%b expected hf=11 ovr=1", half_full, overrun);
        end
        read_line(7'd0, d);
        checks++;
        if (d !== {32'hE3, 32'hE2, 32'hE1, 32'hE0}) begin
            errors++;
            $display("FAIL overrun_line0 got %h expected %h", d, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (overrun !== 1'b0 || half_full !== 2'b11) begin
            errors++;
            $display("FAIL overrun_clr got ovr=%b hf=%b expected ovr=0 hf=11", overrun, half_full);
        end
    endtask

    task automatic test_misalign();
        logic [127:0] d;
        do_reset();
        strobe(32'hA, 1'b1);
        strobe(32'hB, 1'b0);
        checks++;
        if (misalign !== 1'b0) begin
            errors++;
            $display("FAIL first_at_slot0 got %b expected 0", misalign);
        end
        strobe(32'hC, 1'b1);
        checks++;
        if (misalign !== 1'b1) begin
            errors++;
            $display("FAIL misalign_set got %b expected 1", misalign);
        end
        strobe(32'hD, 1'b0);
        strobe(32'hE, 1'b0);
        strobe(32'hF, 1'b0);
        read_line(7'd0, d);
        checks++;
        if (d !== {32'hF, 32'hE, 32'hD, 32'hC}) begin
            errors++;
            $display("FAIL misalign_line0 got %h expected %h", d, {32'hF, 32'hE, 32'hD, 32'hC});
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (misalign !== 1'b0) begin
            errors++;
            $display("FAIL misalign_clr got %b expected 0", misalign);
        end
    endtask

    task automatic test_enable();
        logic [127:0] d;
        do_reset();
        strobe(32'h1, 1'b0);
        strobe(32'h2, 1'b0);
        enable = 1'b0;
        strobe(32'h3, 1'b0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) strobe(32'h90 + i, 1'b0);
        read_line(7'd0, d);
        checks++;
        if (d !== {32'h93, 32'h92, 32'h91, 32'h90}) begin
            errors++;
            $display("FAIL enable_restart got %h expected %h", d, {32'h93, 32'h92, 32'h91, 32'h90});
        end
    endtask

    task automatic test_collide();
        logic [127:0] d;
        do_reset();
        dma_bus.adr = 7'd5;
        dma_bus.wdat = {4{32'h55555555}};
        dma_bus.we = 1'b1;
        @(negedge clk);
        dma_bus.we = 1'b0;
        read_line(7'd5, d);
        checks++;
        if (d !== {4{32'h55555555}}) begin
            errors++;
            $display("FAIL dma_write got %h expected %h", d, {4{32'h55555555}});
        end
        strobe(32'h1, 1'b0);
        strobe(32'h2, 1'b0);
        strobe(32'h3, 1'b0);
        dma_bus.adr = 7'd5;
        dma_bus.wdat = {4{32'hDEADBEEF}};
        dma_bus.we = 1'b1;
        strobe(32'h4, 1'b0);
        dma_bus.we = 1'b0;
        read_line(7'd5, d);
        checks++;
        if (d !== {4{32'h55555555}} || collide !== 1'b1) begin
            errors++;
            $display("FAIL collide_drop got %h col=%b expected %h col=1", d, collide, {4{32'h55555555}});
        end
        read_line(7'd0, d);
        checks++;
        if (d !== {32'h4, 32'h3, 32'h2, 32'h1}) begin
            errors++;
            $display("FAIL collide_line0 got %h expected %h", d, {32'h4, 32'h3, 32'h2, 32'h1});
        end
        dma_bus.adr = 7'd5;
        dma_bus.wdat = {4{32'hDEADBEEF}};
        dma_bus.we = 1'b1;
        #1;
        checks++;
        if (dma_bus.rdat !== {4{32'h55555555}}) begin
            errors++;
            $display("FAIL rdw_old got %h expected %h", dma_bus.rdat, {4{32'h55555555}});
        end
        @(negedge clk);
        dma_bus.we = 1'b0;
        read_line(7'd5, d);
        checks++;
        if (d !== {4{32'hDEADBEEF}} || collide !== 1'b1) begin
            errors++;
            $display("FAIL dma_idle_write got %h col=%b expected %h col=1", d, collide, {4{32'hDEADBEEF}});
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (collide !== 1'b0) begin
            errors++;
            $display("FAIL collide_clr got %b expected 0", collide);
        end
    endtask

    task automatic test_async_reset();
        logic [127:0] d;
        do_reset();
        for (int i = 0; i < 512; i++) strobe(i, 1'b0);
        half_ack = 2'b10;
        @(negedge clk);
        half_ack = 2'b00;
        for (int i = 0; i < 6; i++) strobe(32'hC0 + i, 1'b0);
        checks++;
        if (half_full !== 2'b01 || overrun !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got hf=%b ovr=%b irq=%b expected hf=01 ovr=1 irq=1", half_full, overrun, irq);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({half_full, overrun, misalign, collide, irq} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset got %b expected 000000", {half_full, overrun, misalign, collide, irq});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) strobe(32'hF0 + i, 1'b0);
        read_line(7'd0, d);
        checks++;
        if (d !== {32'hF3, 32'hF2, 32'hF1, 32'hF0} || overrun !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_line0 got %h ovr=%b expected %h ovr=0", d, overrun, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
        end
    endtask

    initial begin
        dma_bus.en = 1'b0;
        dma_bus.we = 1'b0;
        dma_bus.adr = '0;
        dma_bus.wdat = '0;
        @(negedge clk);
        test_reset();
        test_pack();
        test_half_full();
        test_overrun();
        test_misalign();
        test_enable();
        test_collide();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
